// File: rtl/booth_pkg.sv
// Shared definitions for the iterative radix-2 Booth multiplier: FSM states,
// Booth recoding op-codes and the counter-width helper.
package booth_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_NOP = 2'd0,
        OP_ADD = 2'd1,
        OP_SUB = 2'd2
    } booth_op_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: recode {Q[0], Q_-1}, add/sub M into A, then
// arithmetic-shift {A, Q, Q_-1} right by one.
module booth_step
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH+1:0] i_a,
    input  logic [WIDTH:0]   i_q,
    input  logic             i_qm1,
    input  logic [WIDTH:0]   i_m,
    output logic [WIDTH+1:0] o_a,
    output logic [WIDTH:0]   o_q,
    output logic             o_qm1
);

    booth_op_t          w_op;
    logic [WIDTH+1:0]   w_m_ext;
    logic [WIDTH+1:0]   w_sum;

    assign w_m_ext = {i_m[WIDTH], i_m};

    always_comb begin
        w_op = OP_NOP;
        case ({i_q[0], i_qm1})
            2'b01:   w_op = OP_ADD;
            2'b10:   w_op = OP_SUB;
            default: w_op = OP_NOP;
        endcase
    end

    always_comb begin
        w_sum = i_a;
        case (w_op)
            OP_ADD:  w_sum = i_a + w_m_ext;
            OP_SUB:  w_sum = i_a - w_m_ext;
            default: w_sum = i_a;
        endcase
    end

    assign o_a   = {w_sum[WIDTH+1], w_sum[WIDTH+1:1]};
    assign o_q   = {w_sum[0], i_q[WIDTH:1]};
    assign o_qm1 = i_q[0];

endmodule

// File: rtl/seq_booth_multiplier.sv
// Iterative radix-2 Booth multiplier, one partial-product step per clock,
// start/busy/done handshake with back-to-back starts accepted in DONE.
module seq_booth_multiplier
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = clog2(WIDTH + 1);

    state_t             r_state;
    logic [WIDTH+1:0]   r_a;
    logic [WIDTH:0]     r_q;
    logic               r_qm1;
    logic [WIDTH:0]     r_m;
    logic [CW-1:0]      r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [2*WIDTH-1:0] r_product;

    logic [WIDTH:0]     w_ext_m;
    logic [WIDTH:0]     w_ext_q;
    logic [WIDTH+1:0]   w_next_a;
    logic [WIDTH:0]     w_next_q;
    logic               w_next_qm1;
    logic [2*WIDTH+2:0] w_full;

    // One extra operand bit makes signed and unsigned share the same Booth datapath.
    assign w_ext_m = {signed_mode & multiplicand[WIDTH-1], multiplicand};
    assign w_ext_q = {signed_mode & multiplier[WIDTH-1], multiplier};
    assign w_full  = {w_next_a, w_next_q};

    booth_step #(.WIDTH(WIDTH)) u_step (
        .i_a   (r_a),
        .i_q   (r_q),
        .i_qm1 (r_qm1),
        .i_m   (r_m),
        .o_a   (w_next_a),
        .o_q   (w_next_q),
        .o_qm1 (w_next_qm1)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_a       <= '0;
            r_q       <= '0;
            r_qm1     <= 1'b0;
            r_m       <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_product <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_m     <= w_ext_m;
                        r_q     <= w_ext_q;
                        r_a     <= '0;
                        r_qm1   <= 1'b0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    r_a   <= w_next_a;
                    r_q   <= w_next_q;
                    r_qm1 <= w_next_qm1;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(WIDTH)) begin
                        r_product <= w_full[2*WIDTH-1:0];
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= ST_DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign product = r_product;

endmodule

// File: tb/tb_seq_booth_multiplier.sv
// Scoreboard bench: stimulus pushes expected product and done cycle, per-DUT
// monitors pop and compare on every done pulse, and check reset/hold behaviour.
module tb_seq_booth_multiplier;

    typedef struct {
        logic [15:0] p;
        int          c;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        rst_q = 1'b0;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    logic        start4, sm4, busy4, done4;
    logic [3:0]  m4, q4;
    logic [7:0]  prod4;
    logic        start8, sm8, busy8, done8;
    logic [7:0]  m8, q8;
    logic [15:0] prod8;

    exp_t        sb4[$];
    exp_t        sb8[$];
    logic [15:0] held4 = '0;
    logic [15:0] held8 = '0;
    int          blen4 = 0;
    int          blen8 = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    seq_booth_multiplier #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .signed_mode(sm4),
        .multiplicand(m4), .multiplier(q4),
        .busy(busy4), .done(done4), .product(prod4)
    );

    seq_booth_multiplier #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
        .multiplicand(m8), .multiplier(q8),
        .busy(busy8), .done(done8), .product(prod8)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_q) begin
            chk("w4_rst_busy", 32'(busy4), 32'd0);
            chk("w4_rst_done", 32'(done4), 32'd0);
            chk("w4_rst_prod", 32'(prod4), 32'd0);
            sb4.delete();
            held4 = '0;
            blen4 = 0;
        end else begin
            if (busy4) blen4++;
            else if (!done4) blen4 = 0;
            if (done4) begin
                if (sb4.size() == 0) begin
                    chk("w4_unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb4.pop_front();
                    chk("w4_product", 32'(prod4), 32'(e.p[7:0]));
                    chk("w4_done_cycle", 32'(cyc), 32'(e.c));
                    chk("w4_busy_len", 32'(blen4), 32'd5);
                end
                held4 = 16'(prod4);
                blen4 = 0;
            end else begin
                chk("w4_hold", 32'(prod4), 32'(held4[7:0]));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_q) begin
            chk("w8_rst_busy", 32'(busy8), 32'd0);
            chk("w8_rst_done", 32'(done8), 32'd0);
            chk("w8_rst_prod", 32'(prod8), 32'd0);
            sb8.delete();
            held8 = '0;
            blen8 = 0;
        end else begin
            if (busy8) blen8++;
            else if (!done8) blen8 = 0;
            if (done8) begin
                if (sb8.size() == 0) begin
                    chk("w8_unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb8.pop_front();
                    chk("w8_product", 32'(prod8), 32'(e.p));
                    chk("w8_done_cycle", 32'(cyc), 32'(e.c));
                    chk("w8_busy_len", 32'(blen8), 32'd9);
                end
                held8 = prod8;
                blen8 = 0;
            end else begin
                chk("w8_hold", 32'(prod8), 32'(held8));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op4(input logic sm, input logic [3:0] m, input logic [3:0] q, input logic [7:0] p);
        exp_t e;
        start4 = 1'b1; sm4 = sm; m4 = m; q4 = q;
        e.p = 16'(p); e.c = cyc + 6;
        sb4.push_back(e);
        tick();
        start4 = 1'b0; m4 = 4'h0; q4 = 4'h0;
        repeat (5) tick();
    endtask

    task automatic op8(input logic sm, input logic [7:0] m, input logic [7:0] q, input logic [15:0] p);
        exp_t e;
        start8 = 1'b1; sm8 = sm; m8 = m; q8 = q;
        e.p = p; e.c = cyc + 10;
        sb8.push_back(e);
        tick();
        start8 = 1'b0; m8 = 8'h0; q8 = 8'h0;
        repeat (9) tick();
    endtask

    function automatic logic [15:0] model8(input logic sm, input logic [7:0] m, input logic [7:0] q);
        logic signed [15:0] ms, qs;
        logic [15:0] mu, qu;
        ms = $signed(m); qs = $signed(q);
        mu = m;          qu = q;
        return sm ? 16'(ms * qs) : 16'(mu * qu);
    endfunction

    initial begin
        exp_t e;
        rst = 1'b1;
        start4 = 1'b0; sm4 = 1'b0; m4 = '0; q4 = '0;
        start8 = 1'b0; sm8 = 1'b0; m8 = '0; q8 = '0;
        repeat (2) tick();
        rst = 1'b0;
        tick();

        // Signed basics and corners, WIDTH=4
        op4(1'b1, 4'h3, 4'h1, 8'h03);
        op4(1'b1, 4'hA, 4'h7, 8'hD6);
        op4(1'b1, 4'hE, 4'hB, 8'h0A);
        op4(1'b1, 4'hB, 4'hB, 8'h19);
        op4(1'b1, 4'h8, 4'h8, 8'h40);
        op4(1'b1, 4'h8, 4'h7, 8'hC8);
        op4(1'b0, 4'hF, 4'hF, 8'hE1);
        op4(1'b0, 4'h0, 4'hD, 8'h00);
        repeat (3) tick();

        // WIDTH=8 corners
        op8(1'b1, 8'h80, 8'h80, 16'h4000);
        op8(1'b0, 8'hFF, 8'hFF, 16'hFE01);
        op8(1'b1, 8'hFF, 8'h01, 16'hFFFF);
        op8(1'b1, 8'h7F, 8'h80, 16'hC080);

        // Random pairs per mode against the arithmetic model
        for (int md = 0; md < 2; md++) begin
            for (int i = 0; i < 200; i++) begin
                logic [7:0] a, b;
                a = 8'($urandom);
                b = 8'($urandom);
                op8(md[0], a, b, model8(md[0], a, b));
            end
        end
        repeat (3) tick();

        // Back-to-back: start held through DONE, operands switched mid-RUN
        start4 = 1'b1; sm4 = 1'b1; m4 = 4'h3; q4 = 4'h5;
        e.p = 16'h000F; e.c = cyc + 6;
        sb4.push_back(e);
        tick();
        m4 = 4'hD; q4 = 4'h4;
        e.p = 16'h00F4; e.c = cyc - 1 + 12;
        sb4.push_back(e);
        repeat (6) tick();
        start4 = 1'b0;
        repeat (8) tick();

        // Start pulse during RUN with other operands is ignored
        start4 = 1'b1; sm4 = 1'b0; m4 = 4'h9; q4 = 4'hB;
        e.p = 16'h0063; e.c = cyc + 6;
        sb4.push_back(e);
        tick();
        start4 = 1'b0;
        tick();
        start4 = 1'b1; sm4 = 1'b1; m4 = 4'h2; q4 = 4'h2;
        tick();
        start4 = 1'b0;
        repeat (8) tick();

        // Reset mid-RUN aborts; nothing is expected from the aborted op
        start4 = 1'b1; sm4 = 1'b0; m4 = 4'hB; q4 = 4'h3;
        tick();
        start4 = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (8) tick();
        op4(1'b1, 4'h7, 4'hF, 8'hF9);
        repeat (4) tick();

        chk("w4_scoreboard_empty", 32'(sb4.size()), 32'd0);
        chk("w8_scoreboard_empty", 32'(sb8.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
